// File: rtl/jtframe_sdac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtframe_sdac_pkg                                                   |
// | Shared constants for the sigma-delta DAC: dither LFSR seed/taps    |
// | and the midscale helper.                                           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package jtframe_sdac_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Midscale code for a w-bit unsigned sample
  function automatic int unsigned sdac_mid(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_sdac_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtframe_sdac_if                                                    |
// | Sample/control bus and bitstream outputs of the sigma-delta DAC.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface jtframe_sdac_if #(
  parameter int W  = 16,
  parameter int CH = 2
);
  logic              cen;
  logic              snd_stb;
  logic [CH*W-1:0]   snd;
  logic [2:0]        atten;
  logic              mute;
  logic              clip_clr;
  logic [CH-1:0]     dac_out;
  logic [CH-1:0]     clip;

  modport master (
    output cen, snd_stb, snd, atten, mute, clip_clr,
    input  dac_out, clip
  );

  modport slave (
    input  cen, snd_stb, snd, atten, mute, clip_clr,
    output dac_out, clip
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_sdac_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtframe_sdac_ch                                                    |
// | One DAC channel: sample latch with attenuation, optional dither    |
// | saturation and sticky clip, first-order sigma-delta accumulator.   |
// | Optional feature macro: JTFRAME_SDAC_DITHER_EN                     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module jtframe_sdac_ch
  import jtframe_sdac_pkg::*;
#(
  parameter int W          = 16,
  parameter int SIGNED_SND = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         snd_stb,
  input  logic         mute,
`ifdef JTFRAME_SDAC_DITHER_EN
  input  logic         clip_clr,
  input  logic         dither_up,
`endif
  input  logic [W-1:0] sample,
  input  logic [2:0]   atten,
  output logic         dac_out,
  output logic         clip
);

  localparam logic [W-1:0] MID = W'(sdac_mid(W));

  logic        [W-1:0] u;
  logic signed [W-1:0] delta;
  logic signed [W-1:0] scaled;
  logic        [W-1:0] x_new;
  logic        [W-1:0] x;
  logic        [W:0]   acc;

  // Offset-binary view of the sample, then its signed distance from midscale.
  // The distance always fits in W signed bits, so no extra guard bit is needed.
  assign u      = (SIGNED_SND != 0) ? {~sample[W-1], sample[W-2:0]} : sample;
  assign delta  = $signed({~u[W-1], u[W-2:0]});
  assign scaled = delta >>> atten;

`ifdef JTFRAME_SDAC_DITHER_EN
  logic signed [W+1:0] target;
  logic                ovf;

  // Dither of +/-1 can push the result one code past either rail
  assign target = $signed({2'b00, MID})
                + $signed({{2{scaled[W-1]}}, scaled})
                + $signed({{(W+1){~dither_up}}, 1'b1});

  // Saturate to the unsigned code range and flag the overflow
  always_comb begin
    x_new = target[W-1:0];
    ovf   = 1'b0;
    if (target[W+1]) begin
      x_new = '0;
      ovf   = 1'b1;
    end else if (target[W]) begin
      x_new = '1;
      ovf   = 1'b1;
    end
  end

  // Sticky clip: a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)                         clip <= 1'b0;
    else if (snd_stb && !mute && ovf) clip <= 1'b1;
    else if (clip_clr)               clip <= 1'b0;
  end
`else
  // Without dither the attenuated value never leaves the code range
  assign x_new = MID + $unsigned(scaled);
  assign clip  = 1'b0;
`endif

  // Sample latch: mute pins midscale and overrides a strobe
  always_ff @(posedge clk) begin
    if (rst || mute)  x <= MID;
    else if (snd_stb) x <= x_new;
  end

  // First-order modulator; the carry bit is the output bitstream
  always_ff @(posedge clk) begin
    if (rst)      acc <= '0;
    else if (cen) acc <= {1'b0, acc[W-1:0]} + {1'b0, x};
  end

  assign dac_out = acc[W];

endmodule
`default_nettype wire

// File: rtl/jtframe_sdac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtframe_sdac                                                       |
// | Multi-channel first-order sigma-delta audio DAC.                   |
// | Optional feature macro: JTFRAME_SDAC_DITHER_EN (shared LFSR dither |
// | and clip detection; clip reads 0 when undefined).                  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module jtframe_sdac
  import jtframe_sdac_pkg::*;
#(
  parameter int W          = 16,
  parameter int CH         = 2,
  parameter int SIGNED_SND = 1
) (
  input  logic          clk,
  input  logic          rst,
  jtframe_sdac_if.slave bus
);

  logic [CH-1:0] dac_vec;
  logic [CH-1:0] clip_vec;

`ifdef JTFRAME_SDAC_DITHER_EN
  logic [15:0] lfsr;

  // Galois LFSR shared by all channels, stepped at the modulator rate
  always_ff @(posedge clk) begin
    if (rst)          lfsr <= LFSR_SEED;
    else if (bus.cen) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end
`endif

  generate
    for (genvar k = 0; k < CH; k++) begin : g_ch
      jtframe_sdac_ch #(
        .W          (W),
        .SIGNED_SND (SIGNED_SND)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .cen       (bus.cen),
        .snd_stb   (bus.snd_stb),
        .mute      (bus.mute),
`ifdef JTFRAME_SDAC_DITHER_EN
        .clip_clr  (bus.clip_clr),
        .dither_up (lfsr[0]),
`endif
        .sample    (bus.snd[k*W +: W]),
        .atten     (bus.atten),
        .dac_out   (dac_vec[k]),
        .clip      (clip_vec[k])
      );
    end
  endgenerate

  assign bus.dac_out = dac_vec;
  assign bus.clip    = clip_vec;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtframe_sdac                                                    |
// | Self-checking bench for jtframe_sdac with an arithmetic reference  |
// | model of the latch, attenuation, dither and modulator.             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_jtframe_sdac;

  localparam int W          = 16;
  localparam int CH         = 2;
  localparam int SIGNED_SND = 1;
  localparam int MID        = 1 << (W - 1);
  localparam int FULL       = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtframe_sdac_if #(.W(W), .CH(CH)) bus ();

  jtframe_sdac #(.W(W), .CH(CH), .SIGNED_SND(SIGNED_SND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  int            m_acc [CH];
  int            m_x   [CH];
  logic [CH-1:0] m_clip;
  logic [15:0]   m_lfsr;

  int passed = 0;
  int total  = 0;

  // unclamped latch value from the sample rules
  function automatic int raw_latch(input logic [W-1:0] s, input int a, input int dith);
    int u;
    u = (SIGNED_SND != 0) ? (int'(s) ^ MID) : int'(s);
    return MID + ((u - MID) >>> a) + dith;
  endfunction

  function automatic logic [CH-1:0] exp_dac();
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = (m_acc[k] >= FULL);
    return r;
  endfunction

  // advance model with the inputs currently applied, then clock the DUT
  task automatic tick();
    int t, dith;
    logic set;
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        m_acc[k] = 0;
        m_x[k]   = MID;
      end
      m_clip = '0;
      m_lfsr = 16'hACE1;
    end else begin
`ifdef JTFRAME_SDAC_DITHER_EN
      dith = m_lfsr[0] ? 1 : -1;
`else
      dith = 0;
`endif
      for (int k = 0; k < CH; k++) begin
        set = 1'b0;
        if (bus.cen) m_acc[k] = (m_acc[k] % FULL) + m_x[k];
        if (bus.mute) m_x[k] = MID;
        else if (bus.snd_stb) begin
          t = raw_latch(bus.snd[k*W +: W], int'(bus.atten), dith);
          if (t < 0)            begin t = 0;        set = 1'b1; end
          else if (t > FULL-1)  begin t = FULL - 1; set = 1'b1; end
          m_x[k] = t;
        end
        if (set)               m_clip[k] = 1'b1;
        else if (bus.clip_clr) m_clip[k] = 1'b0;
      end
      if (bus.cen) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cen = 1'b0; bus.snd_stb = 1'b0; bus.mute = 1'b0; bus.clip_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cen = 1'b1; bus.snd_stb = 1'b1; bus.snd = $urandom; bus.atten = 3'($urandom);
    bus.mute = 1'b0; bus.clip_clr = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.dac_out !== 2'b00) $display("FAIL reset_dac: got %b want 00", bus.dac_out); else passed++;
    total++;
    if (bus.clip !== 2'b00) $display("FAIL reset_clip: got %b want 00", bus.clip); else passed++;
    rst = 1'b0; bus.snd_stb = 1'b0; bus.cen = 1'b0;
    tick();
    total++;
    if (bus.dac_out !== 2'b00) $display("FAIL idle_after_reset: got %b want 00", bus.dac_out); else passed++;
    bus.cen = 1'b1;
    tick();
    total++;
    if (bus.dac_out !== 2'b00) $display("FAIL first_cen: got %b want 00", bus.dac_out); else passed++;
    tick();
    total++;
    if (bus.dac_out !== 2'b11) $display("FAIL second_cen: got %b want 11", bus.dac_out); else passed++;
    bus.cen = 1'b0;
  endtask

  // signed zero sample gives midscale: 0,1,0,1,... from the first cen
  task automatic test_alternate();
    int errs = 0;
    logic [CH-1:0] want;
    do_reset();
    bus.snd = '0; bus.atten = 3'd0; bus.snd_stb = 1'b1;
    tick();
    bus.snd_stb = 1'b0; bus.cen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      want = (i % 2 == 1) ? 2'b11 : 2'b00;
      if (bus.dac_out !== want) errs++;
    end
    total++;
    if (errs != 0) $display("FAIL alternate: %0d wrong cycles, want 0", errs); else passed++;
    bus.cen = 1'b0;
  endtask

  // full 2^W window: ch0 x=0 stays silent, ch1 x=0xC000 gives 49152 ones
  task automatic test_two_channel();
    int ones0 = 0, ones1 = 0, errs = 0;
    do_reset();
    bus.snd = {16'h4000, 16'h8000}; bus.atten = 3'd0; bus.snd_stb = 1'b1;
    tick();
    bus.snd_stb = 1'b0; bus.cen = 1'b1;
    bus.snd = $urandom;
    for (int i = 0; i < FULL; i++) begin
      tick();
      ones0 += int'(bus.dac_out[0]);
      ones1 += int'(bus.dac_out[1]);
      if (bus.dac_out !== exp_dac()) errs++;
    end
    total++;
    if (ones0 != 0) $display("FAIL ch0_density: got %0d ones want 0", ones0); else passed++;
    total++;
    if (ones1 != 49152) $display("FAIL ch1_density: got %0d ones want 49152", ones1); else passed++;
    total++;
    if (errs != 0) $display("FAIL two_channel_model: %0d wrong cycles, want 0", errs); else passed++;
    bus.cen = 1'b0;
  endtask

  // 0x7FFF at atten 0 and 1, then an atten change with no strobe
  task automatic test_atten();
    int zeros = 0, ones = 0, errs = 0;
    do_reset();
    bus.snd = {2{16'h7FFF}}; bus.atten = 3'd0; bus.snd_stb = 1'b1;
    tick();
    bus.snd_stb = 1'b0; bus.cen = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (bus.dac_out[0] === 1'b0) zeros++;
      if (bus.dac_out !== exp_dac()) errs++;
    end
    total++;
    if (zeros != 1) $display("FAIL max_code_zeros: got %0d zeros want 1", zeros); else passed++;
    bus.atten = 3'd1; bus.snd_stb = 1'b1;
    tick();
    bus.snd_stb = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones += int'(bus.dac_out[1]);
      if (bus.dac_out !== exp_dac()) errs++;
    end
    total++;
    if (ones < 3070 || ones > 3073) $display("FAIL atten1_density: got %0d ones want about 3072", ones); else passed++;
    bus.atten = 3'd5;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (bus.dac_out !== exp_dac()) errs++;
    end
    total++;
    if (errs != 0) $display("FAIL atten_model: %0d wrong cycles, want 0", errs); else passed++;
    bus.cen = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0, cerrs = 0;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      bus.cen      = ($urandom_range(0, 1) == 1);
      bus.snd_stb  = ($urandom_range(0, 3) == 0);
      bus.mute     = ($urandom_range(0, 15) == 0);
      bus.clip_clr = ($urandom_range(0, 7) == 0);
      bus.atten    = 3'($urandom);
      bus.snd      = $urandom;
      tick();
      if (bus.dac_out !== exp_dac()) errs++;
      if (bus.clip !== m_clip) cerrs++;
    end
    total++;
    if (errs != 0) $display("FAIL random_dac: %0d wrong cycles, want 0", errs); else passed++;
    total++;
    if (cerrs != 0) $display("FAIL random_clip: %0d wrong cycles, want 0", cerrs); else passed++;
    bus.cen = 1'b0; bus.snd_stb = 1'b0; bus.mute = 1'b0; bus.clip_clr = 1'b0;
  endtask

  // mute with strobe ignores the sample; output moves only on cen
  task automatic test_mute_cen();
    int errs = 0, moved = 0;
    logic [CH-1:0] prev;
    do_reset();
    bus.mute = 1'b1; bus.snd_stb = 1'b1; bus.atten = 3'd0;
    for (int i = 0; i < 400; i++) begin
      bus.cen = (i % 4 == 0);
      bus.snd = $urandom_range(0, 1) ? 32'h7FFF7FFF : 32'h80008000;
      prev = bus.dac_out;
      tick();
      if (!bus.cen && bus.dac_out !== prev) moved++;
      if (bus.dac_out !== exp_dac()) errs++;
    end
    bus.mute = 1'b0; bus.snd_stb = 1'b0; bus.cen = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.dac_out !== exp_dac()) errs++;
    end
    total++;
    if (moved != 0) $display("FAIL hold_without_cen: %0d changes, want 0", moved); else passed++;
    total++;
    if (errs != 0) $display("FAIL mute_model: %0d wrong cycles, want 0", errs); else passed++;
    bus.cen = 1'b0;
  endtask

  task automatic test_midstream_reset();
    bus.cen = 1'b1; bus.snd_stb = 1'b1; bus.atten = 3'd0;
    for (int i = 0; i < 50; i++) begin
      bus.snd = $urandom;
      tick();
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.dac_out !== 2'b00 || bus.clip !== 2'b00)
      $display("FAIL midstream_reset: dac %b clip %b want 00 00", bus.dac_out, bus.clip);
    else passed++;
    rst = 1'b0; bus.snd_stb = 1'b0;
    tick();
    total++;
    if (bus.dac_out !== 2'b00) $display("FAIL post_reset_first: got %b want 00", bus.dac_out); else passed++;
    tick();
    total++;
    if (bus.dac_out !== 2'b11) $display("FAIL post_reset_second: got %b want 11", bus.dac_out); else passed++;
    bus.cen = 1'b0;
  endtask

`ifdef JTFRAME_SDAC_DITHER_EN
  task automatic test_dither();
    int cerrs = 0, held = 0;
    do_reset();
    bus.snd = {2{16'h7FFF}}; bus.atten = 3'd0; bus.cen = 1'b1; bus.snd_stb = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.clip_clr = ($urandom_range(0, 1) == 1);
      tick();
      if (bus.clip !== m_clip) cerrs++;
    end
    bus.snd_stb = 1'b0; bus.clip_clr = 1'b1;
    tick();
    total++;
    if (bus.clip !== 2'b00) $display("FAIL clip_clear: got %b want 00", bus.clip); else passed++;
    bus.snd_stb = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.clip !== m_clip) cerrs++;
      if (bus.clip === 2'b11) held++;
    end
    total++;
    if (cerrs != 0) $display("FAIL dither_clip_model: %0d wrong cycles, want 0", cerrs); else passed++;
    total++;
    if (held == 0) $display("FAIL set_beats_clear: got %0d set cycles want >0", held); else passed++;
    bus.snd_stb = 1'b0; bus.clip_clr = 1'b0; bus.cen = 1'b0;
  endtask
`endif

  initial begin
    bus.cen = 1'b0; bus.snd_stb = 1'b0; bus.snd = '0; bus.atten = 3'd0;
    bus.mute = 1'b0; bus.clip_clr = 1'b0;
    test_reset();
    test_alternate();
    test_two_channel();
    test_atten();
    test_random();
    test_mute_cen();
    test_midstream_reset();
`ifdef JTFRAME_SDAC_DITHER_EN
    test_dither();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
